bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Two-client arbiter between the instruction cache and the data cache on one side and the single system bus on the other. It grants the bus to one cache at a time, using round-robin on ties, and holds the grant until that cache's transaction completes. While a client owns the bus, the block routes that client's request/response channels onto the bus. It fans snoop-invalidate responses (tag 0x800) out to both caches at all times.

## Interface
- BUS_TAG_WIDTH, 13, system-bus tag width
- BUS_DATA_WIDTH, 64, system-bus data width
- START_TIMEOUT, 64, cycles a granted client may keep busidle=1 before its grant is revoked
- clk  in  1  system clock
- reset  in  1  reset. One clock; reset is asynchronous and active-high.
- icache_busreq, dcache_busreq  in  1  client requests the bus
- icache_busidle, dcache_busidle  in  1  client has no bus activity (0 = transaction in flight)
- icache_busgrant, dcache_busgrant  out  1  registered grant
- icache_reqcyc, icache_respack / dcache_reqcyc, dcache_respack  in  1  client request/ack strobes
- icache_req / dcache_req  in  BUS_DATA_WIDTH  client request address/data
- icache_reqtag / dcache_reqtag  in  BUS_TAG_WIDTH  client request tag
- icache_respcyc, icache_reqack / dcache_respcyc, dcache_reqack  out  1  gated bus strobes per client
- icache_resp / dcache_resp  out  BUS_DATA_WIDTH  bus_resp fanned out, ungated
- icache_resptag / dcache_resptag  out  BUS_TAG_WIDTH  bus_resptag fanned out, ungated
- bus_reqcyc, bus_respack  out  1  muxed strobes to the system bus
- bus_req  out  BUS_DATA_WIDTH  muxed request
- bus_reqtag  out  BUS_TAG_WIDTH  muxed tag
- bus_respcyc, bus_reqack  in  1  system-bus strobes
- bus_resp  in  BUS_DATA_WIDTH  system-bus response data
- bus_resptag  in  BUS_TAG_WIDTH  system-bus response tag

## Operation
- Registered state: state, owner (I/D), last_owner, timeout counter (16 bits, saturating).
- Reset values: state=IDLE, owner=I, last_owner=D (so icache wins the first tie), both grants=0, counter=0.
- Bus outputs are zero whenever no grant is held.
- State machine:
  - IDLE: if exactly one busreq is high, owner <= that client. If both are high, owner <= the client that is not last_owner. Then go to WAIT with that grant set.
  - WAIT: grant held, counter increments. If owner_busidle==0, go to BUSY and clear the counter. If the counter reaches START_TIMEOUT-1 with busidle still 1, go to RELEASE (revoke).
  - BUSY: grant held. When owner_busidle==1, go to RELEASE.
  - RELEASE: both grants=0, last_owner <= owner, go to IDLE. This is a one-cycle turnaround; it guarantees a gap between owners.
- Request mux: in WAIT/BUSY, bus_reqcyc/respack/req/reqtag equal the owner's inputs combinationally. In IDLE/RELEASE they are all 0.
- Response gating: owner_respcyc = bus_respcyc and owner_reqack = bus_reqack in WAIT/BUSY. The non-owner receives 0 on both, except as below.
- Invalidate broadcast: when bus_respcyc=1 and bus_resptag==13'h800, both icache_respcyc and dcache_respcyc are 1, in any state.
- busreq deasserting in WAIT does not drop the grant; only the busidle handshake or the timeout ends ownership.

## Timing
- Grant latency: busreq high at edge N, state IDLE → grant visible after edge N+1.
- Mux path (client → bus) and response gating path are combinational, zero cycles.
- Release: owner busidle returns to 1 at edge M → grant low after edge M+1 (RELEASE) → IDLE at edge M+2. The earliest next grant is after edge M+3.
- Back-to-back alternation: with both requesting continuously, ownership alternates I, D, I, …
- Reset asserted mid-transaction: outputs clear immediately and asynchronously to reset values. The bus is released; the client is responsible for abandoning its transaction.
- Simultaneous busreq rise and RELEASE: the request is sampled in the following IDLE cycle.

## Test plan
- Single dcache request: dcache_busreq=1 at cycle 2 → dcache_busgrant=1 from cycle 3. Drive dcache_reqcyc=1, req=0x1000 → bus_req=0x1000 in the same cycle. busidle 0 for 10 cycles then 1 → grant low the cycle after.
- Tie after reset: both busreq=1 in cycle 2 → icache granted first. Complete it → dcache granted next. Request both again → icache granted.
- Response gating: icache owns the bus; bus_respcyc=1, resptag=0x100, resp=0xABCD → icache_respcyc=1, dcache_respcyc=0, and both resp outputs=0xABCD.
- Invalidate broadcast: idle bus; bus_respcyc=1, resptag=0x800, resp=0x8000_0040 → both respcyc=1, bus_reqcyc=0.
- Timeout: dcache granted, busidle held at 1 → grant dropped after 64 cycles in WAIT. last_owner=D; a pending icache_busreq is then granted.
- Async reset: assert reset mid-BUSY, between clock edges → grants and bus_reqcyc go 0 before the next edge. After release, the first tie goes to icache.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-client bus arbiter: grants the system bus to the icache or dcache,
// round-robin on ties, and holds the grant until the owner goes idle again.
// Ports:
//   clk, reset                      - clock, async active-high reset
//   {i,d}cache_busreq/busidle       - client bus request / idle status
//   {i,d}cache_busgrant             - registered grants
//   {i,d}cache_reqcyc/respack/req/reqtag - client request channel
//   {i,d}cache_respcyc/reqack/resp/resptag - per-client response channel
//   bus_reqcyc/respack/req/reqtag   - muxed request channel to the bus
//   bus_respcyc/reqack/resp/resptag - response channel from the bus
module bus_arbiter #(
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BUS_DATA_WIDTH = 64,
    parameter int START_TIMEOUT  = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      icache_busreq,
    input  logic                      dcache_busreq,
    input  logic                      icache_busidle,
    input  logic                      dcache_busidle,
    output logic                      icache_busgrant,
    output logic                      dcache_busgrant,
    input  logic                      icache_reqcyc,
    input  logic                      icache_respack,
    input  logic [BUS_DATA_WIDTH-1:0] icache_req,
    input  logic [BUS_TAG_WIDTH-1:0]  icache_reqtag,
    input  logic                      dcache_reqcyc,
    input  logic                      dcache_respack,
    input  logic [BUS_DATA_WIDTH-1:0] dcache_req,
    input  logic [BUS_TAG_WIDTH-1:0]  dcache_reqtag,
    output logic                      icache_respcyc,
    output logic                      icache_reqack,
    output logic [BUS_DATA_WIDTH-1:0] icache_resp,
    output logic [BUS_TAG_WIDTH-1:0]  icache_resptag,
    output logic                      dcache_respcyc,
    output logic                      dcache_reqack,
    output logic [BUS_DATA_WIDTH-1:0] dcache_resp,
    output logic [BUS_TAG_WIDTH-1:0]  dcache_resptag,
    output logic                      bus_reqcyc,
    output logic                      bus_respack,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_respcyc,
    input  logic                      bus_reqack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        BUSY    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // Owner encoding: 0 = icache, 1 = dcache
    localparam logic                     OWN_I   = 1'b0;
    localparam logic                     OWN_D   = 1'b1;
    localparam logic [15:0]              TO_LAST = 16'(START_TIMEOUT - 1);
    localparam logic [BUS_TAG_WIDTH-1:0] INV_TAG = BUS_TAG_WIDTH'('h800);

    state_t      r_state, w_state_nxt;
    logic        r_owner, w_owner_nxt;
    logic        r_last,  w_last_nxt;
    logic [15:0] r_cnt,   w_cnt_nxt;
    logic        r_igrant, r_dgrant;
    logic        w_own_idle;
    logic        w_hold;
    logic        w_inv;

    assign w_own_idle = (r_owner == OWN_D) ? dcache_busidle : icache_busidle;

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (icache_busreq || dcache_busreq) begin
                    w_state_nxt = WAIT;
                    if (icache_busreq && dcache_busreq)
                        w_owner_nxt = ~r_last;
                    else
                        w_owner_nxt = dcache_busreq ? OWN_D : OWN_I;
                end
            end
            WAIT: begin
                if (!w_own_idle) begin
                    w_state_nxt = BUSY;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == TO_LAST) begin
                    // Owner never started a transaction: revoke
                    w_state_nxt = RELEASE;
                end else if (r_cnt != 16'hFFFF) begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            BUSY: begin
                if (w_own_idle)
                    w_state_nxt = RELEASE;
            end
            RELEASE: begin
                w_last_nxt  = r_owner;
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_hold = (w_state_nxt == WAIT) || (w_state_nxt == BUSY);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_owner  <= OWN_I;
            r_last   <= OWN_D;
            r_cnt    <= '0;
            r_igrant <= 1'b0;
            r_dgrant <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
            r_last   <= w_last_nxt;
            r_cnt    <= w_cnt_nxt;
            r_igrant <= w_hold && (w_owner_nxt == OWN_I);
            r_dgrant <= w_hold && (w_owner_nxt == OWN_D);
        end
    end

    assign icache_busgrant = r_igrant;
    assign dcache_busgrant = r_dgrant;

    // Grant bits are high exactly in WAIT/BUSY, so they double as mux selects
    assign bus_reqcyc  = (r_igrant & icache_reqcyc)  | (r_dgrant & dcache_reqcyc);
    assign bus_respack = (r_igrant & icache_respack) | (r_dgrant & dcache_respack);
    assign bus_req     = ({BUS_DATA_WIDTH{r_igrant}} & icache_req)
                       | ({BUS_DATA_WIDTH{r_dgrant}} & dcache_req);
    assign bus_reqtag  = ({BUS_TAG_WIDTH{r_igrant}} & icache_reqtag)
                       | ({BUS_TAG_WIDTH{r_dgrant}} & dcache_reqtag);

    // Snoop invalidates reach both caches regardless of ownership
    assign w_inv = bus_respcyc && (bus_resptag == INV_TAG);

    assign icache_respcyc = (r_igrant & bus_respcyc) | w_inv;
    assign dcache_respcyc = (r_dgrant & bus_respcyc) | w_inv;
    assign icache_reqack  = r_igrant & bus_reqack;
    assign dcache_reqack  = r_dgrant & bus_reqack;
    assign icache_resp    = bus_resp;
    assign dcache_resp    = bus_resp;
    assign icache_resptag = bus_resptag;
    assign dcache_resptag = bus_resptag;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter: grants, tie-break, muxing,
// response gating, invalidate broadcast, timeout and async reset.
module tb_bus_arbiter;

    localparam int TW = 13;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          icache_busreq, dcache_busreq;
    logic          icache_busidle, dcache_busidle;
    logic          icache_busgrant, dcache_busgrant;
    logic          icache_reqcyc, icache_respack;
    logic [DW-1:0] icache_req;
    logic [TW-1:0] icache_reqtag;
    logic          dcache_reqcyc, dcache_respack;
    logic [DW-1:0] dcache_req;
    logic [TW-1:0] dcache_reqtag;
    logic          icache_respcyc, icache_reqack;
    logic [DW-1:0] icache_resp;
    logic [TW-1:0] icache_resptag;
    logic          dcache_respcyc, dcache_reqack;
    logic [DW-1:0] dcache_resp;
    logic [TW-1:0] dcache_resptag;
    logic          bus_reqcyc, bus_respack;
    logic [DW-1:0] bus_req;
    logic [TW-1:0] bus_reqtag;
    logic          bus_respcyc, bus_reqack;
    logic [DW-1:0] bus_resp;
    logic [TW-1:0] bus_resptag;

    int n_chk = 0;
    int n_err = 0;

    bus_arbiter #(
        .BUS_TAG_WIDTH (TW),
        .BUS_DATA_WIDTH(DW),
        .START_TIMEOUT (64)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .icache_busreq  (icache_busreq),
        .dcache_busreq  (dcache_busreq),
        .icache_busidle (icache_busidle),
        .dcache_busidle (dcache_busidle),
        .icache_busgrant(icache_busgrant),
        .dcache_busgrant(dcache_busgrant),
        .icache_reqcyc  (icache_reqcyc),
        .icache_respack (icache_respack),
        .icache_req     (icache_req),
        .icache_reqtag  (icache_reqtag),
        .dcache_reqcyc  (dcache_reqcyc),
        .dcache_respack (dcache_respack),
        .dcache_req     (dcache_req),
        .dcache_reqtag  (dcache_reqtag),
        .icache_respcyc (icache_respcyc),
        .icache_reqack  (icache_reqack),
        .icache_resp    (icache_resp),
        .icache_resptag (icache_resptag),
        .dcache_respcyc (dcache_respcyc),
        .dcache_reqack  (dcache_reqack),
        .dcache_resp    (dcache_resp),
        .dcache_resptag (dcache_resptag),
        .bus_reqcyc     (bus_reqcyc),
        .bus_respack    (bus_respack),
        .bus_req        (bus_req),
        .bus_reqtag     (bus_reqtag),
        .bus_respcyc    (bus_respcyc),
        .bus_reqack     (bus_reqack),
        .bus_resp       (bus_resp),
        .bus_resptag    (bus_resptag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; land 1 time unit after the rising edge
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic grants(input string tag, input logic ig, input logic dg);
        chk({tag, ".ig"}, 64'(icache_busgrant), 64'(ig));
        chk({tag, ".dg"}, 64'(dcache_busgrant), 64'(dg));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        icache_busreq  = 0; dcache_busreq  = 0;
        icache_busidle = 1; dcache_busidle = 1;
        icache_reqcyc  = 0; icache_respack = 0;
        icache_req     = '0; icache_reqtag = '0;
        dcache_reqcyc  = 0; dcache_respack = 0;
        dcache_req     = '0; dcache_reqtag = '0;
        bus_respcyc    = 0; bus_reqack     = 0;
        bus_resp       = '0; bus_resptag   = '0;

        // Reset state
        tick(2);
        grants("rst", 0, 0);
        chk("rst.reqcyc", 64'(bus_reqcyc), 64'd0);
        reset = 1'b0;
        tick(1);
        grants("idle", 0, 0);

        // Single dcache request
        dcache_busreq = 1;
        tick(1);
        grants("d.grant", 0, 1);
        dcache_reqcyc = 1;
        dcache_req    = 64'h1000;
        dcache_reqtag = 13'h5;
        dcache_busreq = 0;
        #1;
        chk("d.bus_req", bus_req, 64'h1000);
        chk("d.bus_reqcyc", 64'(bus_reqcyc), 64'd1);
        chk("d.bus_reqtag", 64'(bus_reqtag), 64'h5);
        dcache_busidle = 0;
        tick(10);
        grants("d.busy", 0, 1);
        dcache_busidle = 1;
        dcache_reqcyc  = 0;
        tick(1);
        grants("d.rel", 0, 0);
        chk("d.rel.bus_req", bus_req, 64'd0);
        tick(1);
        grants("d.idle", 0, 0);

        // Tie after reset: icache first
        do_reset();
        icache_busreq = 1;
        dcache_busreq = 1;
        tick(1);
        grants("tie1", 1, 0);
        icache_busidle = 0;
        tick(1);

        // Response gating while icache owns the bus
        bus_respcyc = 1;
        bus_resptag = 13'h100;
        bus_resp    = 64'hABCD;
        bus_reqack  = 1;
        #1;
        chk("gate.irc", 64'(icache_respcyc), 64'd1);
        chk("gate.drc", 64'(dcache_respcyc), 64'd0);
        chk("gate.iresp", icache_resp, 64'hABCD);
        chk("gate.dresp", dcache_resp, 64'hABCD);
        chk("gate.ira", 64'(icache_reqack), 64'd1);
        chk("gate.dra", 64'(dcache_reqack), 64'd0);
        bus_respcyc = 0;
        bus_reqack  = 0;
        bus_resptag = '0;
        bus_resp    = '0;

        icache_busreq  = 0;
        icache_busidle = 1;
        tick(1);
        grants("tie1.rel", 0, 0);
        tick(1);
        grants("tie1.idle", 0, 0);
        tick(1);
        grants("tie2", 0, 1);
        dcache_busidle = 0;
        tick(1);
        dcache_busidle = 1;
        tick(1);
        grants("tie2.rel", 0, 0);
        icache_busreq = 1;
        tick(1);
        tick(1);
        grants("tie3", 1, 0);
        icache_busreq  = 0;
        dcache_busreq  = 0;
        icache_busidle = 0;
        tick(1);
        icache_busidle = 1;
        tick(2);
        grants("tie3.end", 0, 0);

        // Invalidate broadcast on an idle bus
        bus_respcyc = 1;
        bus_resptag = 13'h800;
        bus_resp    = 64'h8000_0040;
        #1;
        chk("inv.irc", 64'(icache_respcyc), 64'd1);
        chk("inv.drc", 64'(dcache_respcyc), 64'd1);
        chk("inv.reqcyc", 64'(bus_reqcyc), 64'd0);
        chk("inv.iresp", icache_resp, 64'h8000_0040);
        bus_resptag = 13'h801;
        #1;
        chk("noinv.irc", 64'(icache_respcyc), 64'd0);
        chk("noinv.drc", 64'(dcache_respcyc), 64'd0);
        bus_respcyc = 0;
        bus_resptag = '0;
        bus_resp    = '0;

        // Timeout: dcache granted but never starts
        dcache_busreq = 1;
        tick(1);
        grants("to.grant", 0, 1);
        dcache_busreq = 0;
        icache_busreq = 1;
        tick(63);
        grants("to.63", 0, 1);
        tick(1);
        grants("to.64", 0, 0);
        tick(1);
        grants("to.idle", 0, 0);
        tick(1);
        grants("to.next", 1, 0);

        // Async reset mid-BUSY
        icache_busidle = 0;
        icache_reqcyc  = 1;
        icache_busreq  = 0;
        tick(1);
        chk("ar.pre", 64'(bus_reqcyc), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        grants("ar", 0, 0);
        chk("ar.reqcyc", 64'(bus_reqcyc), 64'd0);
        tick(1);
        reset          = 1'b0;
        icache_reqcyc  = 0;
        icache_busidle = 1;
        icache_busreq  = 1;
        dcache_busreq  = 1;
        tick(1);
        grants("ar.tie", 1, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
